writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: selects the instruction result, waits for late load data,
// and emits one register-file write / retire pulse per accepted instruction.
// Optional feature macro: WB_CSR_SOURCE_EN (in_sel = 100 selects in_csr).
module writeback_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic               in_regwrite,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_alu,
  input  logic [XLEN-1:0]    in_pc4,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_csr,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               retire,
  output logic               busy,
  output logic [63:0]        instret
);

  localparam logic [2:0] SEL_ALU  = 3'b000;
  localparam logic [2:0] SEL_LOAD = 3'b001;
  localparam logic [2:0] SEL_PC4  = 3'b010;
  localparam logic [2:0] SEL_IMM  = 3'b011;
  localparam logic [2:0] SEL_CSR  = 3'b100;

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e               state_q, state_d;
  logic [RADDR_W-1:0]   pend_rd_q, pend_rd_d;
  logic                 pend_rw_q, pend_rw_d;
  logic                 retire_q, retire_d;
  logic                 rf_we_q, rf_we_d;
  logic [RADDR_W-1:0]   rf_waddr_q, fire_rd;
  logic [XLEN-1:0]      rf_wdata_q, fire_data;
  logic                 fire_rw;
  logic [63:0]          instret_q;
  logic [XLEN-1:0]      src_c;

`ifndef WB_CSR_SOURCE_EN
  logic unused_csr;
  assign unused_csr = ^in_csr;
`endif

  // Non-load result source mux; unassigned codes fall back to the ALU result.
  always_comb begin
    src_c = in_alu;
    case (in_sel)
      SEL_ALU: src_c = in_alu;
      SEL_PC4: src_c = in_pc4;
      SEL_IMM: src_c = in_imm;
`ifdef WB_CSR_SOURCE_EN
      SEL_CSR: src_c = in_csr;
`endif
      default: src_c = in_alu;
    endcase
  end

  // Next-state and completion decode: an instruction completes either at
  // accept (non-load or load with data present) or when pending load data arrives.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    pend_rw_d = pend_rw_q;
    retire_d  = 1'b0;
    fire_rd   = '0;
    fire_rw   = 1'b0;
    fire_data = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sel == SEL_LOAD && !mem_rvalid) begin
            state_d   = WAIT_LOAD;
            pend_rd_d = in_rd;
            pend_rw_d = in_regwrite;
          end else begin
            retire_d  = 1'b1;
            fire_rd   = in_rd;
            fire_rw   = in_regwrite;
            fire_data = (in_sel == SEL_LOAD) ? mem_rdata : src_c;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_d   = IDLE;
          retire_d  = 1'b1;
          fire_rd   = pend_rd_q;
          fire_rw   = pend_rw_q;
          fire_data = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    rf_we_d = retire_d && fire_rw && (fire_rd != '0);
  end

  // State and pending-load register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      pend_rw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_rw_q <= pend_rw_d;
    end
  end

  // Output registers: write port holds its last value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      instret_q  <= '0;
    end else begin
      retire_q  <= retire_d;
      rf_we_q   <= rf_we_d;
      instret_q <= instret_q + 64'(retire_d);
      if (rf_we_d) begin
        rf_waddr_q <= fire_rd;
        rf_wdata_q <= fire_data;
      end
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_LOAD);
  assign retire   = retire_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign instret  = instret_q;

endmodule
